// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial nibble adder: slice width and controller state type.
package serial_add_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;
endpackage

// File: rtl/adder_slice4.sv
// Combinational 4-bit ripple-carry adder slice built from four full adders.
module adder_slice4
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder: one shared 4-bit slice walks the operands LSB nibble first.
// Define SERIAL_ADD_CTRL_ADD_SUB_EN to add the op port and the subtract path.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
`ifdef SERIAL_ADD_CTRL_ADD_SUB_EN
  input  logic                         op,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = $clog2(NIBBLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               cout_q;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;
  logic               accept;
  logic               last;
  logic               carry_init;

`ifdef SERIAL_ADD_CTRL_ADD_SUB_EN
  logic op_q;

  // Subtract as A + ~B + 1: invert B per slice, seed the carry with 1.
  assign slice_b    = b_q[NIBBLE_W*cnt_q +: NIBBLE_W] ^ {NIBBLE_W{op_q}};
  assign carry_init = op;
`else
  assign slice_b    = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];
  assign carry_init = 1'b0;
`endif

  assign slice_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
  assign last    = (cnt_q == CNT_W'(NIBBLES - 1));

  adder_slice4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= carry_init;
      end else if (state_q == RUN) begin
        sum_q[NIBBLE_W*cnt_q +: NIBBLE_W] <= slice_sum;
        carry_q <= slice_cout;
        cnt_q   <= cnt_q + 1'b1;
        if (last) cout_q <= slice_cout;
      end
    end
  end

  // Operands are sampled only on the accepting handshake and held through RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
`ifdef SERIAL_ADD_CTRL_ADD_SUB_EN
      op_q <= op;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed plus random bench for serial_add_ctrl (NIBBLES = 4) against an arithmetic reference.
module tb_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
`ifdef SERIAL_ADD_CTRL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADD_CTRL_ADD_SUB_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic; carry for add, NOT-borrow (a >= b) for subtract.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top,
                       output logic [W-1:0] es, output logic ec);
    logic [W:0] full;
    if (SUB_EN && top) begin
      es = ta - tb_;
      ec = (ta >= tb_);
    end else begin
      full = {1'b0, ta} + {1'b0, tb_};
      es   = full[W-1:0];
      ec   = full[W];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic top, input bit junk);
    logic [W-1:0] es;
    logic         ec;
    model(ta, tb_, top, es, ec);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = ta; b = tb_; op = top;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      chk({tag, " early out_valid"}, 32'(out_valid), 32'd0);
      if (junk) begin
        in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " busy in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " sum"}, 32'(sum), 32'(es));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " released"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst sum", 32'(sum), 32'd0);
    chk("rst cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    txn("add5555", 16'h1234, 16'h4321, 1'b0, 1'b0);
    txn("addFFFF", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    txn("add0FFF", 16'h0FFF, 16'h0001, 1'b0, 1'b0);
    txn("addzero", 16'h0000, 16'h0000, 1'b0, 1'b1);
    txn("addmax",  16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    if (SUB_EN) begin
      txn("sub57", 16'h0005, 16'h0007, 1'b1, 1'b0);
      txn("sub75", 16'h0007, 16'h0005, 1'b1, 1'b0);
      txn("subeq", 16'hA5A5, 16'hA5A5, 1'b1, 1'b1);
    end

    // Backpressure: result held while new operands wait outside the busy block.
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NIBBLES) @(negedge clk);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; a = 16'h8000; b = 16'h8001; op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp hold sum", 32'(sum), 32'h3333);
      chk("bp hold cout", 32'(cout), 32'd0);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle in_ready", 32'(in_ready), 32'd1);
    chk("bp idle out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp run in_ready", 32'(in_ready), 32'd0);
    repeat (NIBBLES) @(negedge clk);
    chk("bp new out_valid", 32'(out_valid), 32'd1);
    chk("bp new sum", 32'(sum), 32'h0001);
    chk("bp new cout", 32'(cout), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of RUN aborts the pair.
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    for (int i = 0; i < NIBBLES + 1; i++) begin
      @(negedge clk);
      chk("abort no output", 32'(out_valid), 32'd0);
    end

    for (int n = 0; n < 24; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = SUB_EN ? 1'($urandom) : 1'b0;
      txn($sformatf("rnd%0d", n), ra, rb, rop, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: operand pair offered.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-006 SHALL have port a, input, W: operand A.
REQ-007 SHALL have port b, input, W: operand B.
REQ-008 SHALL have port op, input, 1: 0 = add, 1 = subtract; present only with ADD_SUB_EN.
REQ-009 SHALL have port out_valid, output, 1: result available.
REQ-010 SHALL have port out_ready, input, 1: consumer takes result.
REQ-011 SHALL have port sum, output, W: result.
REQ-012 SHALL have port cout, output, 1: carry out of the top slice (add); NOT-borrow (subtract).

Function
REQ-013 SHALL sequence one shared 4-bit adder slice over NIBBLES cycles, least significant nibble first, with a registered carry between slices.
REQ-014 SHALL implement states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 IDLE: on in_valid & in_ready, SHALL latch a, b (and op), clear nibble counter to 0, load carry with 0 (add) or 1 (subtract), and go to RUN.
REQ-016 RUN: each cycle SHALL add nibble[cnt] of A and B (B inverted when subtracting) plus carry, write the result into sum[4*cnt+3:4*cnt], update carry, and increment cnt.
REQ-017 RUN SHALL go to DONE on the cycle cnt = NIBBLES-1 completes; cout SHALL take that cycle's slice carry.
REQ-018 Latency: handshake accepted at edge k -> out_valid high after edge k+NIBBLES; next in_ready no earlier than one cycle after output handshake.
REQ-019 DONE: sum and cout SHALL hold stable while out_ready = 0; on out_ready = 1 SHALL go to IDLE.
REQ-020 in_valid outside IDLE SHALL be ignored, with no effect on latched operands; operands SHALL NOT be re-sampled during RUN.
REQ-021 Arithmetic SHALL be modulo 2^W; overflow is reported only via cout.
REQ-022 sum bits not yet written in RUN SHALL keep their previous value; only the DONE value is defined.

Reset
REQ-023 rst = 1 at an edge SHALL force IDLE, cnt = 0, carry = 0, sum = 0, cout = 0, out_valid = 0; in_ready = 1 on the first cycle after reset.
REQ-024 rst SHALL take priority over every handshake; reset during RUN or DONE SHALL abort the operation with no output produced.

Configuration
REQ-025 With macro SERIAL_ADD_CTRL_ADD_SUB_EN defined, SHALL provide port op and the subtract path (B inverted, initial carry 1).
REQ-026 Without SERIAL_ADD_CTRL_ADD_SUB_EN, port op and the inversion logic SHALL be absent, and the block SHALL only add with initial carry 0.

Structure
REQ-027 A shared package serial_add_pkg SHALL hold NIBBLE_W = 4 and the state enum type (IDLE, RUN, DONE).
REQ-028 The 4-bit slice SHALL be one sub-module, adder_slice4 (a, b, cin -> sum, cout, ripple of four full adders), instantiated exactly once.

Verification (NIBBLES = 4)
REQ-029 Add a=16'h1234, b=16'h4321 accepted at edge k -> out_valid after edge k+4, sum=16'h5555, cout=0.
REQ-030 Carry chain a=16'hFFFF, b=16'h0001 -> sum=16'h0000, cout=1; a=16'h0FFF, b=16'h0001 -> sum=16'h1000, cout=0.
REQ-031 Backpressure: out_ready held 0 for 3 cycles in DONE with in_valid=1 and new operands -> sum/cout stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE, then the new pair is accepted.
REQ-032 rst pulsed after 2 RUN cycles -> next cycle IDLE, all outputs 0, in_ready=1, no out_valid for the aborted pair.
REQ-033 With ADD_SUB_EN: op=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0; op=1, a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
